// File: rtl/clock_pkg.sv
// Shared widths, limits and the packed time record for the HH:MM:SS clock.
package clock_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [HR_W-1:0]  hh;
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
  } time_t;

  // True when every field of t is inside its legal range for the given hour modulus.
  function automatic logic fields_valid(input time_t t, input int hours);
    return (int'(t.ss) <= SEC_MAX) && (int'(t.mm) <= MIN_MAX) && (int'(t.hh) < hours);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear/load and a terminal-count carry.
// carry is combinational (en at MOD-1) so the next field advances on the same edge.
module mod_counter #(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count,
  output logic         carry
);

  logic at_max;

  assign at_max = (count == W'(MOD - 1));
  assign carry  = en && at_max;

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          count <= '0;
    else if (clr)      count <= '0;
    else if (ld)       count <= ld_val;
    else if (en)       count <= at_max ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/digital_clock_hms.sv
// HH:MM:SS timekeeper: prescaler to a 1 s tick, cascaded ss/mm/hh counters,
// validated time load and registered rollover/error strobes.
// Optional alarm: define DIGITAL_CLOCK_ALARM_EN to add the alarm ports and logic.
module digital_clock_hms
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int HOURS   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [HR_W-1:0]  load_hh,
  input  logic [MIN_W-1:0] load_mm,
  input  logic [SEC_W-1:0] load_ss,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic             sec_tick,
  output logic             hour_roll,
  output logic             load_err
`ifdef DIGITAL_CLOCK_ALARM_EN
  ,
  input  logic             alarm_set,
  input  logic [HR_W-1:0]  alarm_hh,
  input  logic [MIN_W-1:0] alarm_mm,
  input  logic             alarm_ack,
  output logic             alarm
`endif
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          pre_last;
  logic          tick;
  logic          ld_ok;
  logic          ld_bad;
  logic          ss_carry;
  logic          mm_carry;
  logic          hh_carry;
  time_t         ld_t;

  assign ld_t     = '{hh: load_hh, mm: load_mm, ss: load_ss};
  assign ld_ok    = load && fields_valid(ld_t, HOURS);
  assign ld_bad   = load && !fields_valid(ld_t, HOURS);
  assign pre_last = (pre == PW'(CLK_DIV - 1));
  // Any load (accepted or rejected) suppresses the tick so a rejected load leaves state untouched.
  assign tick     = en && !load && pre_last;

  // Prescaler: accepted load restarts the second, en low or any load freezes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               pre <= '0;
    else if (ld_ok)         pre <= '0;
    else if (en && !load)   pre <= pre_last ? '0 : pre + 1'b1;
  end

  mod_counter #(.W(SEC_W), .MOD(SEC_MAX + 1)) u_ss (
    .clk(clk), .rst(rst), .en(tick), .clr(1'b0), .ld(ld_ok), .ld_val(load_ss),
    .count(seconds), .carry(ss_carry)
  );

  mod_counter #(.W(MIN_W), .MOD(MIN_MAX + 1)) u_mm (
    .clk(clk), .rst(rst), .en(ss_carry), .clr(1'b0), .ld(ld_ok), .ld_val(load_mm),
    .count(minutes), .carry(mm_carry)
  );

  mod_counter #(.W(HR_W), .MOD(HOURS)) u_hh (
    .clk(clk), .rst(rst), .en(mm_carry), .clr(1'b0), .ld(ld_ok), .ld_val(load_hh),
    .count(hours), .carry(hh_carry)
  );

  // Strobes registered alongside the counters so they line up with the new time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_tick  <= 1'b0;
      hour_roll <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= tick;
      hour_roll <= hh_carry;
      load_err  <= ld_bad;
    end
  end

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic             armed;
  logic [HR_W-1:0]  al_hh;
  logic [MIN_W-1:0] al_mm;
  logic [MIN_W-1:0] nxt_mm;
  logic [HR_W-1:0]  nxt_hh;
  logic             al_hit;

  // Time the counters will show after this edge when seconds wrap to :00.
  always_comb begin
    nxt_mm = mm_carry ? '0 : minutes + 1'b1;
    nxt_hh = hh_carry ? '0 : (mm_carry ? hours + 1'b1 : hours);
    al_hit = ss_carry && (nxt_mm == al_mm) && (nxt_hh == al_hh);
  end

  // Alarm latch/arm and sticky alarm flag; ack wins over a same-cycle hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      al_hh <= '0;
      al_mm <= '0;
      alarm <= 1'b0;
    end else begin
      if (alarm_set) begin
        armed <= 1'b1;
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
      end
      if (alarm_ack)              alarm <= 1'b0;
      else if (armed && al_hit)   alarm <= 1'b1;
    end
  end
`endif

endmodule
